keypad_loader: RTL

Keypad entry front end for the microwave timer. It collects decimal key presses into a three-digit buffer (minutes, tens of seconds, ones of seconds) and drives the parallel load interface (`loadn`, per-digit data) of the timer counter chain when start is pressed. It then enables the chain until the chain reports zero or the user cancels. It sits between the keypad debouncer/encoder and the mod-10/mod-6/mod-10 down-counter chain.

---
 rtl/timer_pkg.sv | 19 +
 rtl/keypad_loader_if.sv | 27 ++
 rtl/bcd_entry_shift.sv | 37 +++
 rtl/keypad_loader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave timer keypad front end.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOAD,
        ARMED
    } loader_state_t;

    localparam logic [1:0] TIMER_DIGITS = 2'd3;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/keypad_loader_if.sv
// Keypad/strobe inputs and counter-chain load/enable outputs of the keypad loader.
interface keypad_loader_if;

    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       cancel;
    logic       timer_zero;
    logic       loadn;
    logic [3:0] data_ones;
    logic [3:0] data_tens;
    logic [3:0] data_mins;
    logic       en;
    logic       done;
    logic       key_err;

    modport slave (
        input  key_valid, key_digit, start, cancel, timer_zero,
        output loadn, data_ones, data_tens, data_mins, en, done, key_err
    );

    modport master (
        output key_valid, key_digit, start, cancel, timer_zero,
        input  loadn, data_ones, data_tens, data_mins, en, done, key_err
    );

endinterface

// File: rtl/bcd_entry_shift.sv
// Three-digit BCD entry buffer: new digits enter at ones and push older ones left.
module bcd_entry_shift (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_shift,
    input  logic [3:0] i_digit,
    output logic [3:0] o_ones,
    output logic [3:0] o_tens,
    output logic [3:0] o_mins,
    output logic [1:0] o_count
);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] r_mins;
    logic [1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_mins  <= 4'd0;
            r_count <= 2'd0;
        end else if (i_shift) begin
            r_ones  <= i_digit;
            r_tens  <= r_ones;
            r_mins  <= r_tens;
            r_count <= r_count + 2'd1;
        end
    end

    assign o_ones  = r_ones;
    assign o_tens  = r_tens;
    assign o_mins  = r_mins;
    assign o_count = r_count;

endmodule

// File: rtl/keypad_loader.sv
// Keypad entry FSM that loads and enables the mod-10/mod-6/mod-10 timer chain.
// Optional feature macro: KEYPAD_LOADER_TENS_CHECK_EN (reject keys that would put >5 in tens).
module keypad_loader
    import timer_pkg::*;
#(
    parameter int LOAD_CYCLES = 1
) (
    input logic             clock,
    input logic             clear,
    keypad_loader_if.slave  kl
);

    loader_state_t r_state;
    logic          r_loadn;
    logic          r_en;
    logic          r_done;
    logic          r_arm_first;
    logic [3:0]    r_load_cnt;
`ifdef KEYPAD_LOADER_TENS_CHECK_EN
    logic          r_key_err;
    logic          w_key_rej;
`endif

    logic [3:0] w_ones;
    logic [3:0] w_tens;
    logic [3:0] w_mins;
    logic [1:0] w_count;
    logic       w_key_ok;
    logic       w_tens_ok;
    logic       w_start_ok;
    logic       w_cancel;
    logic       w_zero_hit;
    logic       w_buf_zero;
    logic       w_key_slot;
    logic       w_shift;
    logic       w_buf_clr;

    bcd_entry_shift u_shift (
        .i_clk   (clock),
        .i_clr   (w_buf_clr),
        .i_shift (w_shift),
        .i_digit (kl.key_digit),
        .o_ones  (w_ones),
        .o_tens  (w_tens),
        .o_mins  (w_mins),
        .o_count (w_count)
    );

    // Priority decode: clear > cancel > start > key.
    always_comb begin
        w_key_ok   = kl.key_valid && is_bcd(kl.key_digit);
`ifdef KEYPAD_LOADER_TENS_CHECK_EN
        w_tens_ok  = (w_ones <= TENS_MAX);
`else
        w_tens_ok  = 1'b1;
`endif
        w_buf_zero = (w_ones == 4'd0) && (w_tens == 4'd0) && (w_mins == 4'd0);
        w_start_ok = kl.start && (r_state == ENTRY);
        w_cancel   = kl.cancel && (r_state != IDLE);
        w_zero_hit = (r_state == ARMED) && !r_arm_first && kl.timer_zero && r_loadn;
        w_key_slot = !w_cancel && !w_start_ok && w_key_ok &&
                     ((r_state == IDLE) || ((r_state == ENTRY) && (w_count < TIMER_DIGITS)));
        w_shift    = w_key_slot && w_tens_ok;
`ifdef KEYPAD_LOADER_TENS_CHECK_EN
        w_key_rej  = w_key_slot && !w_tens_ok;
`endif
        w_buf_clr  = clear || w_cancel || w_zero_hit || (w_start_ok && w_buf_zero);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            r_loadn     <= 1'b1;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_arm_first <= 1'b0;
            r_load_cnt  <= 4'd0;
`ifdef KEYPAD_LOADER_TENS_CHECK_EN
            r_key_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef KEYPAD_LOADER_TENS_CHECK_EN
            r_key_err <= w_key_rej;
`endif
            if (w_cancel) begin
                r_state     <= IDLE;
                r_loadn     <= 1'b1;
                r_en        <= 1'b0;
                r_arm_first <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_shift) r_state <= ENTRY;
                    end
                    ENTRY: begin
                        if (w_start_ok) begin
                            if (w_buf_zero) begin
                                r_state <= IDLE;
                            end else begin
                                r_state    <= LOAD;
                                r_loadn    <= 1'b0;
                                r_load_cnt <= 4'(LOAD_CYCLES - 1);
                            end
                        end
                    end
                    LOAD: begin
                        // en rises on the same edge that releases loadn, so the two never overlap.
                        if (r_load_cnt == 4'd0) begin
                            r_state     <= ARMED;
                            r_loadn     <= 1'b1;
                            r_en        <= 1'b1;
                            r_arm_first <= 1'b1;
                        end else begin
                            r_load_cnt <= r_load_cnt - 4'd1;
                        end
                    end
                    ARMED: begin
                        r_arm_first <= 1'b0;
                        if (w_zero_hit) begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_loadn <= 1'b1;
                        r_en    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_LOADER_TENS_CHECK_EN
    assign kl.data_tens = w_tens;
    assign kl.key_err   = r_key_err;
`else
    function automatic logic [3:0] sat_tens(input logic [3:0] t);
        return (t > TENS_MAX) ? TENS_MAX : t;
    endfunction

    // Unchecked entry can hold 6-9 in tens; clamp it while the mod-6 counter is loading.
    assign kl.data_tens = (r_state == LOAD) ? sat_tens(w_tens) : w_tens;
    assign kl.key_err   = 1'b0;
`endif

    assign kl.loadn     = r_loadn;
    assign kl.en        = r_en;
    assign kl.done      = r_done;
    assign kl.data_ones = w_ones;
    assign kl.data_mins = w_mins;

endmodule
